// File: rtl/msg_link_defs.sv
// Shared definitions for the serial message link: receiver state encodings and default bit timing.
package msg_link_defs;

  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_STOP      = 3'd3;
  localparam logic [2:0] RX_WAIT_HIGH = 3'd4;

  localparam int DEFAULT_CLOCKS_PER_BIT = 868;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; resets to INIT so an idle line reads idle.
module sync_2ff #(
  parameter logic INIT = 1'b1
) (
  input  logic Clock,
  input  logic Clear,
  input  logic data_i,
  output logic data_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      meta_q <= INIT;
      sync_q <= INIT;
    end else begin
      meta_q <= data_i;
      sync_q <= meta_q;
    end
  end

  assign data_o = sync_q;

endmodule

// File: rtl/serial_byte_receiver.sv
// 8N1 LSB-first serial receiver: mid-bit sampling, start-glitch rejection, framing-error flag,
// and a one-cycle strobe per good byte for the downstream message router.
//
//  state        | meaning
//  RX_IDLE      | line idle, waiting for a falling edge
//  RX_START     | timing to the start-bit mid-point to confirm it
//  RX_DATA      | sampling 8 data bits at bit mid-points
//  RX_STOP      | sampling the stop bit
//  RX_WAIT_HIGH | bad stop bit seen, waiting for the line to return high
module serial_byte_receiver
  import msg_link_defs::*;
#(
  parameter int ClocksPerBit = DEFAULT_CLOCKS_PER_BIT
) (
  input  logic       Clock,
  input  logic       Clear,
  input  logic       SerialIn,
  output logic [7:0] MessageByte,
  output logic       MessageByteReady,
  output logic       FramingError,
  output logic       Busy
);

  localparam int CW = $clog2(ClocksPerBit);
  localparam logic [CW-1:0] FULL_TC = CW'(ClocksPerBit - 1);
  localparam logic [CW-1:0] HALF_TC = CW'(ClocksPerBit / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          rx;
  logic [2:0]    state_q,  state_d;
  logic [CW-1:0] clkcnt_q, clkcnt_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q,  shreg_d;
  logic [7:0]    byte_q,   byte_d;
  logic          ready_q,  ready_d;
  logic          ferr_q,   ferr_d;

  sync_2ff #(.INIT(1'b1)) u_sync_rx (
    .Clock  (Clock),
    .Clear  (Clear),
    .data_i (SerialIn),
    .data_o (rx)
  );

  always_comb begin
    state_d  = state_q;
    clkcnt_d = clkcnt_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    byte_d   = byte_q;
    ready_d  = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx) begin
          state_d  = RX_START;
          clkcnt_d = '0;
        end
      end
      RX_START: begin
        if (clkcnt_q == HALF_TC) begin
          if (rx) begin
            state_d = RX_IDLE;
          end else begin
            state_d  = RX_DATA;
            clkcnt_d = '0;
            bitcnt_d = '0;
          end
        end else begin
          clkcnt_d = clkcnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (clkcnt_q == FULL_TC) begin
          clkcnt_d = '0;
          shreg_d  = {rx, shreg_q[7:1]};
          if (bitcnt_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else begin
          clkcnt_d = clkcnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (clkcnt_q == FULL_TC) begin
          clkcnt_d = '0;
          // Leaving at the stop-bit mid-point lets an immediately following start edge be caught.
          if (rx) begin
            byte_d  = shreg_q;
            ready_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAIT_HIGH;
          end
        end else begin
          clkcnt_d = clkcnt_q + CNT_ONE;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q  <= RX_IDLE;
      clkcnt_q <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      byte_q   <= '0;
      ready_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      clkcnt_q <= clkcnt_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      byte_q   <= byte_d;
      ready_q  <= ready_d;
      ferr_q   <= ferr_d;
    end
  end

  assign MessageByte      = byte_q;
  assign MessageByteReady = ready_q;
  assign FramingError     = ferr_q;
  assign Busy             = (state_q != RX_IDLE);

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Directed bench for serial_byte_receiver at 16 clocks per bit.
module tb_serial_byte_receiver;

  localparam int CPB = 16;

  logic       clk;
  logic       Clear;
  logic       SerialIn;
  logic [7:0] MessageByte;
  logic       MessageByteReady;
  logic       FramingError;
  logic       Busy;

  int n_cmp  = 0;
  int n_fail = 0;

  int         cyc = 0;
  logic [7:0] rx_bytes[$];
  int         rx_cyc[$];
  int         ferr_cnt = 0;
  int         strobe_viol = 0;
  int         busy_fall_cyc = -1;
  logic       busy_seen = 1'b0;
  logic       prev_ready = 1'b0;
  logic       prev_ferr = 1'b0;
  logic       prev_busy = 1'b0;

  serial_byte_receiver #(.ClocksPerBit(CPB)) dut (
    .Clock            (clk),
    .Clear            (Clear),
    .SerialIn         (SerialIn),
    .MessageByte      (MessageByte),
    .MessageByteReady (MessageByteReady),
    .FramingError     (FramingError),
    .Busy             (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (MessageByteReady) begin
      rx_bytes.push_back(MessageByte);
      rx_cyc.push_back(cyc);
    end
    if (FramingError) ferr_cnt++;
    if (MessageByteReady && FramingError) strobe_viol++;
    if ((MessageByteReady || FramingError) && (prev_ready || prev_ferr)) strobe_viol++;
    if (prev_busy && !Busy) busy_fall_cyc = cyc;
    if (Busy) busy_seen = 1'b1;
    prev_ready = MessageByteReady;
    prev_ferr  = FramingError;
    prev_busy  = Busy;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input int idx);
    if (idx < rx_bytes.size()) return rx_bytes[idx];
    return 8'hxx;
  endfunction

  function automatic int cyc_at(input int idx);
    if (idx < rx_cyc.size()) return rx_cyc[idx];
    return -1;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    SerialIn = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int stop_len);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    SerialIn = stop;
    repeat (stop_len) @(negedge clk);
  endtask

  task automatic clear_log();
    rx_bytes.delete();
    rx_cyc.delete();
  endtask

  logic [7:0] hdr_seq[7] = '{8'h7E, 8'd101, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
  int f0;

  initial begin
    Clear    = 1'b0;
    SerialIn = 1'b1;
    idle(3);
    check_val("rst_byte",  {24'd0, MessageByte}, 32'h00);
    check_val("rst_ready", {31'd0, MessageByteReady}, 32'd0);
    check_val("rst_ferr",  {31'd0, FramingError}, 32'd0);
    check_val("rst_busy",  {31'd0, Busy}, 32'd0);
    Clear = 1'b1;
    idle(5);

    // 1: single good byte
    clear_log();
    f0 = ferr_cnt;
    send_byte(8'hA5, 1'b1, CPB);
    idle(20);
    check_val("t1_count", rx_bytes.size(), 32'd1);
    check_val("t1_byte",  {24'd0, byte_at(0)}, 32'hA5);
    check_val("t1_ferr",  ferr_cnt - f0, 32'd0);
    check_val("t1_busy_fall", busy_fall_cyc, cyc_at(0));

    // 2: back-to-back frames, no idle gap
    clear_log();
    send_byte(8'h00, 1'b1, CPB);
    send_byte(8'hFF, 1'b1, CPB);
    idle(20);
    check_val("t2_count", rx_bytes.size(), 32'd2);
    check_val("t2_byte0", {24'd0, byte_at(0)}, 32'h00);
    check_val("t2_byte1", {24'd0, byte_at(1)}, 32'hFF);
    check_val("t2_spacing", cyc_at(1) - cyc_at(0), 32'd160);

    // 3: start-bit glitch
    clear_log();
    f0 = ferr_cnt;
    busy_seen = 1'b0;
    SerialIn = 1'b0;
    idle(4);
    SerialIn = 1'b1;
    idle(10);
    check_val("t3_busy_seen", {31'd0, busy_seen}, 32'd1);
    check_val("t3_busy_low",  {31'd0, Busy}, 32'd0);
    idle(20);
    check_val("t3_no_ready", rx_bytes.size(), 32'd0);
    check_val("t3_no_ferr",  ferr_cnt - f0, 32'd0);

    // 4: framing error, held-low line, then recovery
    clear_log();
    send_byte(8'h11, 1'b1, CPB);
    idle(10);
    f0 = ferr_cnt;
    send_byte(8'h3C, 1'b0, 40);
    check_val("t4_ferr_once", ferr_cnt - f0, 32'd1);
    check_val("t4_byte_held", {24'd0, MessageByte}, 32'h11);
    check_val("t4_busy_low_line", {31'd0, Busy}, 32'd1);
    check_val("t4_ready_count", rx_bytes.size(), 32'd1);
    SerialIn = 1'b1;
    idle(10);
    check_val("t4_busy_released", {31'd0, Busy}, 32'd0);
    send_byte(8'h7E, 1'b1, CPB);
    idle(20);
    check_val("t4_recover_count", rx_bytes.size(), 32'd2);
    check_val("t4_recover_byte", {24'd0, byte_at(1)}, 32'h7E);

    // 5: reset mid-frame (during bit 4 of 8'hC3)
    clear_log();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'hC3 >> i));
    SerialIn = 1'b1;
    idle(CPB / 2);
    check_val("t5_busy_before", {31'd0, Busy}, 32'd1);
    Clear = 1'b0;
    #1;
    check_val("t5_clr_byte",  {24'd0, MessageByte}, 32'h00);
    check_val("t5_clr_busy",  {31'd0, Busy}, 32'd0);
    check_val("t5_clr_ready", {31'd0, MessageByteReady}, 32'd0);
    check_val("t5_clr_ferr",  {31'd0, FramingError}, 32'd0);
    idle(3);
    Clear = 1'b1;
    idle(5);
    send_byte(8'h5A, 1'b1, CPB);
    idle(20);
    check_val("t5_count", rx_bytes.size(), 32'd1);
    check_val("t5_byte",  {24'd0, byte_at(0)}, 32'h5A);

    // 6: header plus data burst as the router would see it
    clear_log();
    for (int i = 0; i < 7; i++) send_byte(hdr_seq[i], 1'b1, CPB);
    idle(20);
    check_val("t6_count", rx_bytes.size(), 32'd7);
    for (int i = 0; i < 7; i++)
      check_val($sformatf("t6_byte%0d", i), {24'd0, byte_at(i)}, {24'd0, hdr_seq[i]});

    check_val("strobe_rules", strobe_viol, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
